pc_redirect_ctrl: RTL

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 20 ++
 rtl/pc_redirect_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch-PC redirect controller.
// Holds the controller state encoding, width defaults and reset PC.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int          PC_W_DEF  = 9;
    localparam int          CNT_W_DEF = 16;
    localparam logic [31:0] RESET_PC  = 32'd0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Asynchronous active-high reset clears it to zero.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential fetch, execute-stage redirects,
// deferred redirects while imem is busy, and a sticky illegal-target trap.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Stall,
    input  logic             ImemReady,
    output logic [PC_W-1:0]  Cur_PC,
    output logic             Flush_IF,
    output logic             Flush_ID,
    output logic             Fault,
    output logic [CNT_W-1:0] Redirect_Cnt
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pend_q;
    logic [PC_W-1:0] pend_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] br_pc;
    logic            legal;
    logic            cnt_inc;
    logic            flush;

    assign br_pc = BrPC[PC_W-1:0];
    // Target must be word aligned and fit inside the PC space.
    assign legal = (BrPC[1:0] == 2'b00) && ((BrPC >> PC_W) == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            Cur_PC <= PC_W'(RESET_PC);
            pend_q <= '0;
        end else begin
            state  <= state_nxt;
            Cur_PC <= pc_nxt;
            pend_q <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (PcSel) begin
                    if (!legal) begin
                        state_nxt = FAULT;
                    end else if (!ImemReady) begin
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (PcSel && !legal) begin
                    state_nxt = FAULT;
                end else if (ImemReady) begin
                    state_nxt = RUN;
                end
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_nxt   = Cur_PC;
        pend_nxt = pend_q;
        flush    = (state != RUN) || PcSel;
        Fault    = (state == FAULT);
        cnt_inc  = PcSel && legal && (state != FAULT);
        unique case (state)
            RUN: begin
                if (PcSel) begin
                    if (legal && ImemReady) begin
                        pc_nxt = br_pc;
                    end else if (legal) begin
                        pend_nxt = br_pc;
                    end
                end else if (!Stall && ImemReady) begin
                    pc_nxt = Cur_PC + PC_W'(4);
                end
            end
            PEND: begin
                // A new request in the same cycle beats the stored one.
                if (PcSel) begin
                    if (legal && ImemReady) begin
                        pc_nxt = br_pc;
                    end else if (legal) begin
                        pend_nxt = br_pc;
                    end
                end else if (ImemReady) begin
                    pc_nxt = pend_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign Flush_IF = flush;
    assign Flush_ID = flush;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cnt_inc),
        .count(Redirect_Cnt)
    );

endmodule
